// File: rtl/hex_entry_buffer.sv
// Hex digit entry buffer: synchronises switches/buttons, detects presses and edits a 16-digit block.
// Optional per-button debounce FSMs are enabled with `define HEX_ENTRY_DEBOUNCE_EN.
module hex_entry_buffer #(
   parameter int unsigned DIGITS          = 16,
   parameter int unsigned CNT_W           = 5,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic                  CLOCK_50,
   input  logic                  rst,
   input  logic                  in0,
   input  logic                  in1,
   input  logic                  in2,
   input  logic                  in3,
   input  logic                  loadButton,
   input  logic                  backspace,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   values,
   output logic [CNT_W-1:0]      nEntered,
   output logic                  full,
   output logic                  entry_pulse,
   output logic                  done_pulse
);

   localparam int unsigned VW     = 4 * DIGITS;
   localparam int unsigned NB     = 3;
   localparam int unsigned BTN_LD = 0;
   localparam int unsigned BTN_BS = 1;
   localparam int unsigned BTN_CL = 2;

   logic [NB-1:0]    btn_s1_q, btn_s2_q;
   logic [3:0]       sw_s1_q, sw_s2_q;
   logic [1:0]       vld_q;
   logic [NB-1:0]    arm_q;
   logic [NB-1:0]    level_c;
   logic [NB-1:0]    press_c;

   logic [VW-1:0]    values_q, values_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             full_q, full_d;
   logic             entry_q, entry_d;
   logic             done_q, done_d;

   // Two-flop synchronisers; vld_q marks when sync2 first reflects a real pin sample
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         btn_s1_q <= '1;
         btn_s2_q <= '1;
         sw_s1_q  <= '1;
         sw_s2_q  <= '1;
         vld_q    <= '0;
      end else begin
         btn_s1_q <= {clear, backspace, loadButton};
         btn_s2_q <= btn_s1_q;
         sw_s1_q  <= {in3, in2, in1, in0};
         sw_s2_q  <= sw_s1_q;
         vld_q    <= {vld_q[0], 1'b1};
      end
   end

   // A button arms only after a genuine released level, so one held through reset stays silent
   always_ff @(posedge CLOCK_50) begin
      if (rst) arm_q <= '0;
      else     arm_q <= arm_q | ({NB{vld_q[1]}} & btn_s2_q & level_c);
   end

`ifdef HEX_ENTRY_DEBOUNCE_EN
   localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESS_WAIT,
      S_HELD,
      S_RELEASE_WAIT
   } db_state_e;

   db_state_e       db_state_q [NB];
   db_state_e       db_state_d [NB];
   logic [DB_W-1:0] db_cnt_q   [NB];
   logic [DB_W-1:0] db_cnt_d   [NB];
   logic [NB-1:0]   press_q, press_d;

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         for (int b = 0; b < NB; b++) begin
            db_state_q[b] <= S_IDLE;
            db_cnt_q[b]   <= '0;
         end
         press_q <= '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            db_state_q[b] <= db_state_d[b];
            db_cnt_q[b]   <= db_cnt_d[b];
         end
         press_q <= press_d;
      end
   end

   // Entering a wait state counts the triggering sample as the first of the run
   always_comb begin
      db_state_d = db_state_q;
      db_cnt_d   = db_cnt_q;
      press_d    = '0;
      level_c    = '0;
      for (int b = 0; b < NB; b++) begin
         level_c[b] = (db_state_q[b] == S_IDLE) || (db_state_q[b] == S_PRESS_WAIT);
         case (db_state_q[b])
            S_IDLE: begin
               if (!btn_s2_q[b]) begin
                  db_state_d[b] = S_PRESS_WAIT;
                  db_cnt_d[b]   = DB_W'(1);
               end
            end
            S_PRESS_WAIT: begin
               if (btn_s2_q[b]) begin
                  db_state_d[b] = S_IDLE;
               end else if (db_cnt_q[b] >= DB_LAST) begin
                  db_state_d[b] = S_HELD;
                  press_d[b]    = arm_q[b];
               end else begin
                  db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
               end
            end
            S_HELD: begin
               if (btn_s2_q[b]) begin
                  db_state_d[b] = S_RELEASE_WAIT;
                  db_cnt_d[b]   = DB_W'(1);
               end
            end
            S_RELEASE_WAIT: begin
               if (!btn_s2_q[b]) begin
                  db_state_d[b] = S_HELD;
               end else if (db_cnt_q[b] >= DB_LAST) begin
                  db_state_d[b] = S_IDLE;
               end else begin
                  db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
               end
            end
            default: db_state_d[b] = S_IDLE;
         endcase
      end
   end

   assign press_c = press_q;
`else
   logic [NB-1:0] prev_q;

   always_ff @(posedge CLOCK_50) begin
      if (rst) prev_q <= '1;
      else     prev_q <= btn_s2_q;
   end

   assign level_c = btn_s2_q;
   assign press_c = arm_q & prev_q & ~btn_s2_q;
`endif

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         values_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         entry_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         values_q <= values_d;
         cnt_q    <= cnt_d;
         full_q   <= full_d;
         entry_q  <= entry_d;
         done_q   <= done_d;
      end
   end

   // Event priority clear > backspace > load; losing events are dropped
   always_comb begin
      values_d = values_q;
      cnt_d    = cnt_q;
      full_d   = full_q;
      entry_d  = 1'b0;
      done_d   = 1'b0;
      if (press_c[BTN_CL]) begin
         values_d = '0;
         cnt_d    = '0;
         full_d   = 1'b0;
         entry_d  = 1'b1;
      end else if (press_c[BTN_BS]) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            for (int unsigned i = 0; i < DIGITS; i++) begin
               if (CNT_W'(i) == cnt_d) values_d[VW-1-4*i -: 4] = 4'h0;
            end
            entry_d = 1'b1;
            full_d  = 1'b0;
         end
      end else if (press_c[BTN_LD]) begin
         if (cnt_q != CNT_W'(DIGITS)) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
               if (CNT_W'(i) == cnt_q) values_d[VW-1-4*i -: 4] = sw_s2_q;
            end
            cnt_d   = cnt_q + CNT_W'(1);
            entry_d = 1'b1;
            if (cnt_q == CNT_W'(DIGITS - 1)) begin
               done_d = 1'b1;
               full_d = 1'b1;
            end
         end
      end
   end

   assign values      = values_q;
   assign nEntered    = cnt_q;
   assign full        = full_q;
   assign entry_pulse = entry_q;
   assign done_pulse  = done_q;

endmodule
